// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer.
package timer_pkg;

    localparam int TIMER_N = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_e;

endpackage

// File: rtl/loadable_down_counter.sv
// Down counter with synchronous load (priority over decrement); never wraps below zero.
module loadable_down_counter #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         LOAD,
    input  logic [N-1:0] DIN,
    input  logic         DEC,
    output logic [N-1:0] COUNT,
    output logic         ONE
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (LOAD) begin
            count_d = DIN;
        end else if (DEC && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;
    assign ONE   = (count_q == {{(N-1){1'b0}}, 1'b1});

endmodule

// File: rtl/interval_timer.sv
// Interval timer: start/period request, one-shot or auto-reload countdown, pause, cancel,
// TICK/DONE expiry signalling with ACK, and sticky OVERRUN for unacknowledged reload ticks.
module interval_timer
    import timer_pkg::*;
#(
    parameter int N = TIMER_N
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [N-1:0] LOAD_VAL,
    input  logic         RELOAD,
    input  logic         PAUSE,
    input  logic         CANCEL,
    input  logic         ACK,
    output logic         BUSY,
    output logic [N-1:0] COUNT,
    output logic         TICK,
    output logic         DONE,
    output logic         OVERRUN,
    output logic         ERR,
    output state_e       DBG_STATE
);

    state_e       state_q, state_d;
    logic [N-1:0] reload_q, reload_d;
    logic         mode_q, mode_d;
    logic         pending_q, pending_d;
    logic         overrun_q, overrun_d;
    logic         done_q, done_d;
    logic         tick_q, tick_d;
    logic         err_q, err_d;
    logic         busy_q, busy_d;

    logic         cnt_load;
    logic [N-1:0] cnt_din;
    logic         cnt_dec;
    logic         cnt_one;
    logic [N-1:0] cnt_value;
    logic         start_accept;
    logic         reload_tick;

    loadable_down_counter #(.N(N)) u_counter (
        .CLK   (CLK),
        .RST   (RST),
        .LOAD  (cnt_load),
        .DIN   (cnt_din),
        .DEC   (cnt_dec),
        .COUNT (cnt_value),
        .ONE   (cnt_one)
    );

    always_comb begin
        state_d      = state_q;
        reload_d     = reload_q;
        mode_d       = mode_q;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        done_d       = done_q;
        tick_d       = 1'b0;
        err_d        = 1'b0;
        cnt_load     = 1'b0;
        cnt_din      = '0;
        cnt_dec      = 1'b0;
        start_accept = 1'b0;
        reload_tick  = 1'b0;

        if (CANCEL) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        if (LOAD_VAL == '0) begin
                            err_d = 1'b1;
                        end else begin
                            start_accept = 1'b1;
                            cnt_load     = 1'b1;
                            cnt_din      = LOAD_VAL;
                            reload_d     = LOAD_VAL;
                            mode_d       = RELOAD;
                            overrun_d    = 1'b0;
                            state_d      = RUN;
                        end
                    end
                end
                RUN: begin
                    if (PAUSE) begin
                        state_d = PAUSED;
                    end else if (!cnt_one) begin
                        cnt_dec = 1'b1;
                    end else begin
                        tick_d   = 1'b1;
                        cnt_load = 1'b1;
                        if (mode_q) begin
                            cnt_din     = reload_q;
                            reload_tick = 1'b1;
                        end else begin
                            done_d  = 1'b1;
                            state_d = EXPIRED;
                        end
                    end
                end
                PAUSED: begin
                    // Resume edge does not decrement; counting restarts on the next edge.
                    if (!PAUSE) begin
                        state_d = RUN;
                    end
                end
                EXPIRED: begin
                    if (ACK) begin
                        done_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A same-cycle ACK retires the previous tick, so the new tick is pending without overrun.
        if (reload_tick) begin
            pending_d = 1'b1;
            if (pending_q && !ACK) begin
                overrun_d = 1'b1;
            end
        end else if (ACK || start_accept) begin
            pending_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            reload_q  <= '0;
            mode_q    <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign BUSY      = busy_q;
    assign COUNT     = cnt_value;
    assign TICK      = tick_q;
    assign DONE      = done_q;
    assign OVERRUN   = overrun_q;
    assign ERR       = err_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer: a cycle-level reference model pushes expected outputs per edge,
// which are popped and compared after the edge, plus directed checks on key scenarios.
module tb_interval_timer;
    import timer_pkg::*;

    localparam int N = 8;
    localparam int W = N + 5;

    logic         CLK;
    logic         RST;
    logic         START;
    logic [N-1:0] LOAD_VAL;
    logic         RELOAD;
    logic         PAUSE;
    logic         CANCEL;
    logic         ACK;
    logic         BUSY;
    logic [N-1:0] COUNT;
    logic         TICK;
    logic         DONE;
    logic         OVERRUN;
    logic         ERR;
    state_e       DBG_STATE;

    interval_timer #(.N(N)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .LOAD_VAL  (LOAD_VAL),
        .RELOAD    (RELOAD),
        .PAUSE     (PAUSE),
        .CANCEL    (CANCEL),
        .ACK       (ACK),
        .BUSY      (BUSY),
        .COUNT     (COUNT),
        .TICK      (TICK),
        .DONE      (DONE),
        .OVERRUN   (OVERRUN),
        .ERR       (ERR),
        .DBG_STATE (DBG_STATE)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_tick_cyc = -1;

    // reference model: 0 idle, 1 run, 2 paused, 3 expired
    int m_st;
    int m_cnt;
    int m_rld;
    bit m_mode;
    bit m_pend;
    bit m_ovr;
    bit m_done;
    bit m_tick;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_rld = 0; m_mode = 0;
        m_pend = 0; m_ovr = 0; m_done = 0; m_tick = 0; m_err = 0;
    endtask

    task automatic model_edge(input bit st, input int lv, input bit rl, input bit ps,
                              input bit cn, input bit ak);
        bit was_pend;
        bit rtick;
        was_pend = m_pend;
        rtick    = 0;
        m_tick   = 0;
        m_err    = 0;
        if (cn) begin
            m_st   = 0;
            m_cnt  = 0;
            m_done = 0;
        end else if (m_st == 0) begin
            if (st && lv == 0) m_err = 1;
            else if (st) begin
                m_cnt = lv; m_rld = lv; m_mode = rl;
                m_ovr = 0; m_pend = 0; m_st = 1;
            end
        end else if (m_st == 1) begin
            if (ps) m_st = 2;
            else if (m_cnt > 1) m_cnt = m_cnt - 1;
            else begin
                m_tick = 1;
                if (!m_mode) begin
                    m_cnt = 0; m_done = 1; m_st = 3;
                end else begin
                    m_cnt = m_rld;
                    rtick = 1;
                    if (was_pend && !ak) m_ovr = 1;
                    m_pend = 1;
                end
            end
        end else if (m_st == 2) begin
            if (!ps) m_st = 1;
        end else begin
            if (ak) begin
                m_done = 0; m_st = 0;
            end
        end
        if (ak && !rtick) m_pend = 0;
    endtask

    // driver: apply one cycle of inputs, predict, then compare after the edge
    task automatic step(input bit st, input int lv, input bit rl, input bit ps,
                        input bit cn, input bit ak);
        logic [W-1:0] e;
        START = st; LOAD_VAL = lv[N-1:0]; RELOAD = rl;
        PAUSE = ps; CANCEL = cn; ACK = ak;
        model_edge(st, lv, rl, ps, cn, ak);
        exp_q.push_back({(m_st != 0), m_cnt[N-1:0], m_tick, m_done, m_ovr, m_err});
        @(posedge CLK);
        #1;
        cyc++;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("busy",    BUSY,    e[W-1]);
            chk("count",   COUNT,   e[W-2:4]);
            chk("tick",    TICK,    e[3]);
            chk("done",    DONE,    e[2]);
            chk("overrun", OVERRUN, e[1]);
            chk("err",     ERR,     e[0]);
        end
        if (TICK) last_tick_cyc = cyc;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    BUSY,    0);
        chk({tag, "_count"},   COUNT,   0);
        chk({tag, "_tick"},    TICK,    0);
        chk({tag, "_done"},    DONE,    0);
        chk({tag, "_overrun"}, OVERRUN, 0);
        chk({tag, "_err"},     ERR,     0);
        chk({tag, "_state"},   DBG_STATE, IDLE);
    endtask

    initial begin
        int s_cyc;
        int held;
        bit ak_next;
        START = 0; LOAD_VAL = '0; RELOAD = 0; PAUSE = 0; CANCEL = 0; ACK = 0;
        RST = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        RST = 1'b0;

        // one-shot L=5: tick/done after edge 5, ack sampled at edge 9
        s_cyc = cyc + 1;
        step(1, 5, 0, 0, 0, 0);
        chk("os_count_load", COUNT, 5);
        idle_cycles(4);
        chk("os_count_one", COUNT, 1);
        idle_cycles(1);
        chk("os_tick_lat", last_tick_cyc - s_cyc, 5);
        chk("os_done", DONE, 1);
        idle_cycles(3);
        chk("os_done_hold", DONE, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("os_busy_drop", BUSY, 0);
        idle_cycles(1);

        // reload L=3, ack one cycle after each tick
        step(1, 3, 1, 0, 0, 0);
        ak_next = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0, ak_next);
            ak_next = m_tick;
        end
        chk("rl3_no_overrun", OVERRUN, 0);
        step(0, 0, 0, 0, 1, 0);

        // reload L=2, never acked: overrun after the second tick, sticky
        step(1, 2, 1, 0, 0, 0);
        idle_cycles(2);
        chk("rl2_first_tick", TICK, 1);
        chk("rl2_ovr_after_first", OVERRUN, 0);
        idle_cycles(2);
        chk("rl2_second_tick", TICK, 1);
        chk("rl2_ovr_after_second", OVERRUN, 1);
        idle_cycles(3);
        chk("rl2_ovr_sticky", OVERRUN, 1);
        step(0, 0, 0, 0, 1, 0);
        step(1, 4, 1, 0, 0, 0);
        chk("rl2_ovr_cleared", OVERRUN, 0);
        step(0, 0, 0, 0, 1, 0);

        // pause for 4 cycles mid-count, L=6
        step(1, 6, 0, 0, 0, 0);
        idle_cycles(2);
        held = COUNT;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        chk("pause_frozen", COUNT, held);
        idle_cycles(8);
        step(0, 0, 0, 0, 0, 1);

        // cancel while COUNT == 1
        step(1, 3, 1, 0, 0, 0);
        idle_cycles(2);
        chk("cancel_pre_one", COUNT, 1);
        step(0, 0, 0, 0, 1, 0);
        chk("cancel_no_tick", TICK, 0);
        chk("cancel_count", COUNT, 0);
        chk("cancel_state", DBG_STATE, IDLE);

        // start with zero period
        step(1, 0, 0, 0, 0, 0);
        chk("err_pulse", ERR, 1);
        chk("err_busy", BUSY, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("err_one_cycle", ERR, 0);

        // constrained random traffic
        for (int i = 0; i < 80; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4), $urandom_range(0, 1),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0);
        end
        step(0, 0, 0, 0, 1, 1);

        // asynchronous reset between edges with COUNT == 4
        step(1, 6, 1, 0, 0, 0);
        idle_cycles(2);
        chk("arst_pre_count", COUNT, 4);
        #3;
        RST = 1'b1;
        #1;
        chk_all_zero("arst");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        exp_q.delete();
        s_cyc = cyc + 1;
        step(1, 2, 0, 0, 0, 0);
        chk("post_rst_count", COUNT, 2);
        idle_cycles(2);
        chk("post_rst_tick_lat", last_tick_cyc - s_cyc, 2);
        step(0, 0, 0, 0, 0, 1);
        idle_cycles(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=finish", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
